// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: default NOP encoding,
// response classification and a constant log2 helper for pointer widths.
package fetch_prefetch_unit_pkg;

    // addi x0, x0, 0: presented to decode whenever no fetched word is available
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // What happens to an instruction-memory response in a given cycle
    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,   // no response this cycle
        RSP_DROP  = 2'd1,   // response belongs to a squashed request
        RSP_FILL  = 2'd2,   // response fills the oldest unfilled ring entry
        RSP_STRAY = 2'd3    // response with nothing waiting for it (protocol error)
    } rsp_kind_t;

    // Ceiling log2, usable in parameter/localparam expressions
    function automatic int fp_clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_ring.sv
// Fetch ring: DEPTH entries of {pc, instr}. Three wrap-bit pointers track the
// entries reserved by issued requests (alloc), the entries whose data has
// returned (fill) and the entry currently offered to decode (head).
module fetch_ring
    import fetch_prefetch_unit_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int ILEN  = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = fp_clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [ILEN-1:0] fill_instr,
    input  logic            pop,
    input  logic            flush,
    output logic [CW-1:0]   used,
    output logic [CW-1:0]   unfilled,
    output logic            head_filled,
    output logic [XLEN-1:0] head_pc,
    output logic [ILEN-1:0] head_instr
);

    logic [CW-1:0]   alloc_ptr_reg;
    logic [CW-1:0]   alloc_ptr_next;
    logic [CW-1:0]   fill_ptr_reg;
    logic [CW-1:0]   fill_ptr_next;
    logic [CW-1:0]   head_ptr_reg;
    logic [CW-1:0]   head_ptr_next;

    logic [AW-1:0]   alloc_idx;
    logic [AW-1:0]   fill_idx;
    logic [AW-1:0]   head_idx;

    // Small storage read asynchronously so the head word is visible to decode
    // in the cycle after it was written, without an extra read stage.
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    logic [DEPTH-1:0] pc_we;
    logic [DEPTH-1:0] instr_we;

    assign alloc_idx = alloc_ptr_reg[AW-1:0];
    assign fill_idx  = fill_ptr_reg[AW-1:0];
    assign head_idx  = head_ptr_reg[AW-1:0];

    // Per-entry write enables; a flush suppresses any write in the same cycle
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign pc_we[gi]    = alloc & ~flush & (alloc_idx == AW'(gi));
            assign instr_we[gi] = fill  & ~flush & (fill_idx  == AW'(gi));
        end
    endgenerate

    // Pointer update: flush collapses fill/head onto alloc, otherwise each strobe advances its pointer
    always_comb begin
        alloc_ptr_next = alloc_ptr_reg;
        fill_ptr_next  = fill_ptr_reg;
        head_ptr_next  = head_ptr_reg;
        if (flush) begin
            fill_ptr_next = alloc_ptr_reg;
            head_ptr_next = alloc_ptr_reg;
        end else begin
            if (alloc) begin
                alloc_ptr_next = alloc_ptr_reg + CW'(1);
            end
            if (fill) begin
                fill_ptr_next = fill_ptr_reg + CW'(1);
            end
            if (pop) begin
                head_ptr_next = head_ptr_reg + CW'(1);
            end
        end
    end

    // Pointer registers, cleared asynchronously so the ring empties immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            head_ptr_reg  <= '0;
        end else begin
            alloc_ptr_reg <= alloc_ptr_next;
            fill_ptr_reg  <= fill_ptr_next;
            head_ptr_reg  <= head_ptr_next;
        end
    end

    // Entry storage: PC written when the request issues, instruction when its response returns
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (pc_we[i]) begin
                pc_mem[i] <= alloc_pc;
            end
            if (instr_we[i]) begin
                instr_mem[i] <= fill_instr;
            end
        end
    end

    assign used        = alloc_ptr_reg - head_ptr_reg;
    assign unfilled    = alloc_ptr_reg - fill_ptr_reg;
    assign head_filled = (fill_ptr_reg != head_ptr_reg);
    assign head_pc     = pc_mem[head_idx];
    assign head_instr  = instr_mem[head_idx];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC and the count of responses
// still owed for squashed requests, decides when to issue, classifies each
// memory response, and gives branch/jump redirect priority over everything.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter int               ILEN      = 32,
    parameter int               DEPTH     = 4,
    parameter logic [XLEN-1:0]  PC_STEP   = XLEN'(1),
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [ILEN-1:0]  NOP_INSTR = ILEN'(NOP_INSTR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr
);

    localparam int CW = fp_clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] fetch_pc_next;
    logic [CW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   drop_cnt_next;

    logic [CW-1:0]   used;
    logic [CW-1:0]   unfilled;
    logic            head_filled;
    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_instr;

    logic [CW:0]     occupancy;
    logic            issue;
    logic            ring_fill;
    logic            ring_pop;
    logic            rsp_consumed;
    rsp_kind_t       rsp_kind;

    // Entries held plus responses still owed to squashed requests bound what may be outstanding
    assign occupancy = {1'b0, used} + {1'b0, drop_cnt_reg};
    assign issue     = ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
    assign imem_req  = issue;
    assign imem_addr = fetch_pc_reg;

    // Classify the incoming response: owed-to-squash first, then oldest unfilled entry
    always_comb begin
        rsp_kind = RSP_NONE;
        if (imem_rvalid) begin
            if (drop_cnt_reg != '0) begin
                rsp_kind = RSP_DROP;
            end else if (unfilled != '0) begin
                rsp_kind = RSP_FILL;
            end else begin
                rsp_kind = RSP_STRAY;
            end
        end
    end

    assign rsp_consumed = (rsp_kind == RSP_DROP) || (rsp_kind == RSP_FILL);
    assign ring_fill    = (rsp_kind == RSP_FILL) & ~redirect_valid;
    assign ring_pop     = head_filled & id_ready & ~redirect_valid;

    // Next fetch PC and drop count; a redirect turns every unfilled entry into an owed response
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        drop_cnt_next = drop_cnt_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            drop_cnt_next = drop_cnt_reg + unfilled - CW'(rsp_consumed);
        end else begin
            if (issue) begin
                fetch_pc_next = fetch_pc_reg + PC_STEP;
            end
            if (rsp_kind == RSP_DROP) begin
                drop_cnt_next = drop_cnt_reg - CW'(1);
            end
        end
    end

    // Fetch PC and drop count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            drop_cnt_reg <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    fetch_ring #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc       (issue),
        .alloc_pc    (fetch_pc_reg),
        .fill        (ring_fill),
        .fill_instr  (imem_rdata),
        .pop         (ring_pop),
        .flush       (redirect_valid),
        .used        (used),
        .unfilled    (unfilled),
        .head_filled (head_filled),
        .head_pc     (head_pc),
        .head_instr  (head_instr)
    );

    assign id_valid = head_filled;
    assign id_pc    = head_filled ? head_pc    : '0;
    assign id_instr = head_filled ? head_instr : NOP_INSTR;

endmodule
